// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and constants for the IS61LV25616 SRAM controller
package sram_ctrl_pkg;

  localparam int SRAM_AW = 18;
  localparam int SRAM_DW = 16;

  localparam logic [1:0] BE_N_IDLE = 2'b11;
  localparam logic [1:0] BE_N_FULL = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WSETUP,
    WPULSE,
    WHOLD
  } sram_state_t;

endpackage

// File: rtl/sram_avalon_ctrl.sv
// rtl/sram_avalon_ctrl.sv - Avalon-MM slave to asynchronous SRAM controller, all pins registered
// Optional SRAM_DQ_INREG_EN: registers sram_dq_read and adds one read dwell cycle.
module sram_avalon_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int AW           = SRAM_AW,
  parameter int DW           = SRAM_DW,
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] avs_address,
  input  logic          avs_read,
  input  logic          avs_write,
  input  logic [DW-1:0] avs_writedata,
  input  logic [1:0]    avs_byteenable,
  output logic          avs_waitrequest,
  output logic [DW-1:0] avs_readdata,
  output logic          avs_readdatavalid,
  output logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_dq_read,
  output logic [DW-1:0] sram_dq_write,
  output logic          sram_dq_en,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic [1:0]    sram_be_n
);

`ifdef SRAM_DQ_INREG_EN
  localparam logic [3:0] RD_CNT_INIT = 4'(READ_CYCLES);
`else
  localparam logic [3:0] RD_CNT_INIT = 4'(READ_CYCLES - 1);
`endif
  localparam logic [3:0] WR_CNT_INIT = 4'(WRITE_CYCLES - 1);

  sram_state_t   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dq_write_q, dq_write_d;
  logic          dq_en_q, dq_en_d;
  logic          ce_n_q, ce_n_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic [1:0]    be_n_q, be_n_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rd_sample;

`ifdef SRAM_DQ_INREG_EN
  logic [DW-1:0] dq_in_q;

  // Pad data is captured unconditionally; the extra RD dwell cycle covers its latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dq_in_q <= '0;
    end else begin
      dq_in_q <= sram_dq_read;
    end
  end

  assign rd_sample = dq_in_q;
`else
  assign rd_sample = sram_dq_read;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      dq_write_q <= '0;
      dq_en_q    <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      be_n_q     <= BE_N_IDLE;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      dq_write_q <= dq_write_d;
      dq_en_q    <= dq_en_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      be_n_q     <= be_n_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    dq_write_d = dq_write_q;
    dq_en_d    = dq_en_q;
    ce_n_d     = ce_n_q;
    oe_n_d     = oe_n_q;
    we_n_d     = we_n_q;
    be_n_d     = be_n_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Write has priority when a master raises both strobes.
        if (avs_write) begin
          addr_d     = avs_address;
          dq_write_d = avs_writedata;
          be_n_d     = ~avs_byteenable;
          dq_en_d    = 1'b1;
          ce_n_d     = 1'b0;
          state_d    = WSETUP;
        end else if (avs_read) begin
          addr_d  = avs_address;
          ce_n_d  = 1'b0;
          oe_n_d  = 1'b0;
          be_n_d  = BE_N_FULL;
          dq_en_d = 1'b0;
          cnt_d   = RD_CNT_INIT;
          state_d = RD;
        end
      end
      RD: begin
        if (cnt_q == 4'd0) begin
          rdata_d  = rd_sample;
          rvalid_d = 1'b1;
          ce_n_d   = 1'b1;
          oe_n_d   = 1'b1;
          be_n_d   = BE_N_IDLE;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WSETUP: begin
        we_n_d  = 1'b0;
        cnt_d   = WR_CNT_INIT;
        state_d = WPULSE;
      end
      WPULSE: begin
        if (cnt_q == 4'd0) begin
          we_n_d  = 1'b1;
          state_d = WHOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WHOLD: begin
        dq_en_d = 1'b0;
        ce_n_d  = 1'b1;
        be_n_d  = BE_N_IDLE;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign avs_waitrequest   = (state_q != IDLE);
  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign sram_addr         = addr_q;
  assign sram_dq_write     = dq_write_q;
  assign sram_dq_en        = dq_en_q;
  assign sram_ce_n         = ce_n_q;
  assign sram_oe_n         = oe_n_q;
  assign sram_we_n         = we_n_q;
  assign sram_be_n         = be_n_q;

endmodule

// File: tb/tb_sram_avalon_ctrl.sv
// tb/tb_sram_avalon_ctrl.sv - self-checking bench for sram_avalon_ctrl with an IS61LV25616 model
module tb_sram_avalon_ctrl;

`ifdef SRAM_DQ_INREG_EN
  localparam int EXP_LAT  = 4;
  localparam int RD_WAIT  = 3;
`else
  localparam int EXP_LAT  = 3;
  localparam int RD_WAIT  = 2;
`endif
  localparam int WR_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [15:0] avs_writedata;
  logic [1:0]  avs_byteenable;
  logic        avs_waitrequest;
  logic [15:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_read;
  logic [15:0] sram_dq_write;
  logic        sram_dq_en;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [1:0]  sram_be_n;

  sram_avalon_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .sram_addr         (sram_addr),
    .sram_dq_read      (sram_dq_read),
    .sram_dq_write     (sram_dq_write),
    .sram_dq_en        (sram_dq_en),
    .sram_ce_n         (sram_ce_n),
    .sram_oe_n         (sram_oe_n),
    .sram_we_n         (sram_we_n),
    .sram_be_n         (sram_be_n)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // IS61LV25616 behavioural model: asynchronous read, byte-laned write while WE_n low.
  logic [15:0] mem [0:262143];
  assign sram_dq_read = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hDEAD;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_en) begin
      if (!sram_be_n[0]) mem[sram_addr][7:0]  = sram_dq_write[7:0];
      if (!sram_be_n[1]) mem[sram_addr][15:8] = sram_dq_write[15:8];
    end
  end

  int viol = 0;
  always @(posedge clk) begin
    if (!sram_oe_n && sram_dq_en) viol = viol + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    int          acc;
  } rd_exp_t;
  rd_exp_t sb[$];

  always @(negedge clk) begin
    if (!reset && avs_readdatavalid) begin
      if (sb.size() == 0) begin
        check("unexpected_rdv", 32'd1, 32'd0);
      end else begin
        rd_exp_t e;
        e = sb.pop_front();
        check("rdata", 32'(avs_readdata), 32'(e.data));
        check("rd_latency", 32'(cyc - e.acc), 32'(EXP_LAT));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge with strobes cleared.
  task automatic do_req(input logic rd, input logic wr, input logic [17:0] a,
                        input logic [15:0] d, input logic [1:0] be,
                        input logic [15:0] exp, output int acc);
    int n;
    avs_address    = a;
    avs_read       = rd;
    avs_write      = wr;
    avs_writedata  = d;
    avs_byteenable = be;
    n = 0;
    while (avs_waitrequest && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("accept_timeout", 32'd0, 32'd1);
    acc = cyc;
    if (rd && !wr) sb.push_back('{exp, cyc});
    @(negedge clk);
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  task automatic measure_wait(output int n);
    n = 0;
    while (avs_waitrequest && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int acc, acc1, acc2, n;
    for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
    reset          = 1'b1;
    avs_address    = '0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_writedata  = '0;
    avs_byteenable = 2'b00;
    repeat (2) @(negedge clk);

    check("rst_ctrl_n", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'd7);
    check("rst_be_n", 32'(sram_be_n), 32'd3);
    check("rst_dq_en", 32'(sram_dq_en), 32'd0);
    check("rst_addr_dq", 32'({sram_addr, sram_dq_write}), 32'd0);
    check("rst_rd", 32'({avs_readdata, avs_readdatavalid}), 32'd0);
    check("rst_wait", 32'(avs_waitrequest), 32'd0);

    reset = 1'b0;
    @(negedge clk);

    // Basic write then read
    do_req(1'b0, 1'b1, 18'h00010, 16'hA5A5, 2'b11, 16'h0, acc);
    measure_wait(n);
    check("wr_wait", 32'(n), 32'(WR_WAIT));
    do_req(1'b1, 1'b0, 18'h00010, 16'h0, 2'b11, 16'hA5A5, acc);
    measure_wait(n);
    check("rd_wait", 32'(n), 32'(RD_WAIT));
    drain();

    // Byte lanes, including an all-disabled write
    do_req(1'b0, 1'b1, 18'h00020, 16'hFFFF, 2'b11, 16'h0, acc);
    do_req(1'b0, 1'b1, 18'h00020, 16'h1234, 2'b01, 16'h0, acc);
    do_req(1'b1, 1'b0, 18'h00020, 16'h0, 2'b11, 16'hFF34, acc);
    drain();
    do_req(1'b0, 1'b1, 18'h00020, 16'h0000, 2'b00, 16'h0, acc);
    check("be00_be_n", 32'(sram_be_n), 32'd3);
    measure_wait(n);
    check("be00_wait", 32'(n), 32'(WR_WAIT));
    do_req(1'b1, 1'b0, 18'h00020, 16'h0, 2'b11, 16'hFF34, acc);
    drain();

    // Back-to-back reads at the address extremes
    mem[18'h3FFFF] = 16'h5A3C;
    mem[18'h00000] = 16'hC0DE;
    do_req(1'b1, 1'b0, 18'h3FFFF, 16'h0, 2'b11, 16'h5A3C, acc1);
    do_req(1'b1, 1'b0, 18'h00000, 16'h0, 2'b11, 16'hC0DE, acc2);
    check("b2b_accept_gap", 32'(acc2 - acc1), 32'(EXP_LAT));
    drain();

    // Simultaneous read and write: write wins, no read data
    do_req(1'b1, 1'b1, 18'h00100, 16'hBEEF, 2'b11, 16'h0, acc);
    measure_wait(n);
    check("rw_wait", 32'(n), 32'(WR_WAIT));
    repeat (4) @(negedge clk);
    do_req(1'b1, 1'b0, 18'h00100, 16'h0, 2'b11, 16'hBEEF, acc);
    drain();

    // Reset in the middle of the write pulse
    do_req(1'b0, 1'b1, 18'h00040, 16'h1111, 2'b11, 16'h0, acc);
    @(negedge clk);
    check("pre_rst_we_n", 32'(sram_we_n), 32'd0);
    reset = 1'b1;
    #1;
    check("midrst_we_n", 32'(sram_we_n), 32'd1);
    check("midrst_ce_n", 32'(sram_ce_n), 32'd1);
    check("midrst_dq_en", 32'(sram_dq_en), 32'd0);
    check("midrst_wait", 32'(avs_waitrequest), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_req(1'b1, 1'b0, 18'h00010, 16'h0, 2'b11, 16'hA5A5, acc);
    drain();

    check("oe_dq_overlap", 32'(viol), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
